game_link: RTL and testbench
============================

# game_link

Byte-level link protocol engine between the local game state machine and the UART byte interface. It runs in the opposite direction to the game FSM:
- From the FSM's state and score, it builds outgoing frames and sends them through the UART transmitter.
- It parses incoming UART bytes into the rival's state and score, then presents `rival_score` and `start_sig` back to the FSM.

## Interface
- `HEARTBEAT_CYCLES`, default 1_000_000: period of the unsolicited STATE frame resend.
- `RX_TIMEOUT_CYCLES`, default 100_000: maximum gap allowed between the header byte and the data byte of one frame.
- `LINK_LOSS_BEATS`, default 4: number of heartbeat periods without a valid frame before `link_up` drops.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous and active-high.
- `state_out` in 2: local FSM state (IDLE=00, WAIT=01, GAME=10, SCORE=11).
- `my_score` in 8: local score. It is valid from the second cycle of SCORE.
- `rx_data` in 8: received byte from the UART receiver.
- `rx_done` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `tx_done` in 1: one-cycle strobe from the UART transmitter when a byte finishes.
- `tx_wr` out 1: one-cycle strobe that starts transmission of `tx_data`.
- `tx_data` out 8: byte to transmit. It is held stable until the matching `tx_done`.
- `rival_score` out 8: last score received in a SCORE frame.
- `rival_state` out 2: last state received in any valid frame.
- `start_sig` out 1: level. High when `state_out`==WAIT and `rival_state` is WAIT or GAME.
- `link_up` out 1: high while valid frames keep arriving.
- `rx_err_cnt` out 8: saturating count of malformed or timed-out frames.

## Operation
- **Frame format:** 2 bytes, HDR then DATA.
  - HDR[7:4] = 4'hA (sync).
  - HDR[3:2] = type: 00 STATE, 01 SCORE, others invalid.
  - HDR[1:0] = sender's state.
  - DATA = 0x00 for STATE, the score for SCORE.
- **RX FSM:** RX_HDR → RX_DATA.
  - RX_HDR: on `rx_done`, if the sync nibble and type are valid, latch the header and go to RX_DATA. Otherwise increment `rx_err_cnt` and stay in RX_HDR.
  - RX_DATA: on `rx_done`, commit the frame and return to RX_HDR.
    - `rival_state` ← HDR[1:0].
    - If type is SCORE, `rival_score` ← `rx_data`.
  - If `RX_TIMEOUT_CYCLES` elapse without a byte, discard the frame, increment `rx_err_cnt` and return to RX_HDR.
  - A STATE frame whose DATA ≠ 0x00 is still committed; no error is counted.
- **TX request flags:** `state_pend` and `score_pend`.
  - `state_pend` is set on any change of `state_out` and on heartbeat expiry.
  - `score_pend` is set in the second consecutive cycle with `state_out`==SCORE, so that `my_score` has settled.
- **TX FSM:** TX_IDLE → TX_HDR → TX_WAIT_HDR → TX_DATA → TX_WAIT_DATA → TX_IDLE.
  - In TX_IDLE, the SCORE request has priority over the STATE request.
  - The state/score snapshot is taken in TX_IDLE when the frame is chosen. The flag is cleared at that same point.
  - `tx_wr` pulses exactly once, in TX_HDR and in TX_DATA.
  - The FSM advances out of a WAIT state only on `tx_done`.
- **Heartbeat counter:** restarts whenever a STATE frame is launched.
- **Link loss:**
  - `link_up` goes to 1 on each committed frame.
  - The link-loss counter is cleared on each committed frame. When it reaches `LINK_LOSS_BEATS`×`HEARTBEAT_CYCLES`, `link_up` goes to 0 and `rival_state` goes to IDLE.

## Timing
- Reset values: `tx_wr`=0, `tx_data`=0x00, `rival_score`=0x00, `rival_state`=00, `start_sig`=0, `link_up`=0, `rx_err_cnt`=0. Both FSMs start in their IDLE/HDR state; both pending flags are 0.
- `rival_score`, `rival_state` and `link_up` update 1 cycle after the DATA byte's `rx_done`.
- `start_sig` is registered: 1 cycle after its inputs.
- `tx_wr` for HDR fires 2 cycles after the triggering `state_out` edge (flag set, then launch).
- DATA `tx_wr` fires 1 cycle after the HDR `tx_done`.
- Simultaneous events:
  - A request arriving during a transmission stays pending. Repeated requests merge into one pending flag, and the frame carries the values current at launch.
  - Heartbeat expiry and a state change in the same cycle produce one frame.
  - `rx_done` and timeout expiry in the same cycle: the byte wins.
- `tx_done` while in TX_IDLE/TX_HDR/TX_DATA is ignored.
- `rx_err_cnt` saturates at 0xFF.
- Asserting `rst` mid-frame aborts both FSMs immediately. No partial byte is retried.

## Structure
- Package `game_link_pkg` holds:
  - state encodings IDLE/WAIT/GAME/SCORE;
  - `SYNC_NIBBLE`=4'hA;
  - frame types `FT_STATE`=2'b00 and `FT_SCORE`=2'b01;
  - RX/TX FSM state enums.
- Sub-module `game_link_rx` contains the RX parser, the timeout counter and the error counter. The top level holds the TX FSM, the heartbeat counter, the link watchdog and the `start_sig` logic.

## Test plan
- Valid RX frame: bytes 0xA4, 0x2A (SCORE, rival IDLE, score 42) → `rival_score`=0x2A and `rival_state`=00 one cycle after the second `rx_done`; `link_up`=1.
- Start handshake: `state_out`=WAIT, receive 0xA1, 0x00 → `start_sig`=1. Then `state_out`=GAME → `start_sig`=0.
- Local WAIT→GAME→SCORE transitions with `my_score`=0xAA:
  - TX emits 0xA1,0x00, then 0xA2,0x00, then 0xA7,0xAA.
  - Each `tx_wr` waits for the preceding `tx_done`.
- Bad sync byte 0x5F, then a header 0xA0 followed by silence for `RX_TIMEOUT_CYCLES` → `rx_err_cnt`=2; `rival_state` is unchanged.
- Link loss:
  - With `HEARTBEAT_CYCLES`=100 and no incoming bytes, a STATE frame is sent every 100 cycles.
  - `link_up` falls 400 cycles after the last valid frame, and `rival_state`=00 at that point.
- Reset mid-transmission (between HDR `tx_done` and DATA) → all outputs return to reset values; after release no DATA byte is sent until a new request.

Source files
------------

// File: rtl/game_link_pkg.sv
// Shared encodings for the game_link byte protocol: FSM states, frame fields and header helpers.
// Combinational helpers only; no latency, no flow control.
package game_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_GAME  = 2'b10,
    ST_SCORE = 2'b11
  } gstate_e;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;
  localparam logic [1:0] FT_STATE    = 2'b00;
  localparam logic [1:0] FT_SCORE    = 2'b01;

  typedef enum logic {
    RX_HDR,
    RX_DATA
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_HDR,
    TX_WAIT_HDR,
    TX_DATA,
    TX_WAIT_DATA
  } tx_state_e;

  function automatic logic [7:0] make_hdr(input logic [1:0] ftype, input logic [1:0] st);
    return {SYNC_NIBBLE, ftype, st};
  endfunction

  function automatic logic hdr_valid(input logic [7:0] b);
    return (b[7:4] == SYNC_NIBBLE) && ((b[3:2] == FT_STATE) || (b[3:2] == FT_SCORE));
  endfunction

endpackage

// File: rtl/game_link_rx.sv
// RX frame parser: HDR then DATA; commit_o pulses combinationally with the DATA byte's rx_done.
// No backpressure: every rx_done byte is consumed; bad headers and timed-out frames bump a saturating counter.
module game_link_rx
  import game_link_pkg::*;
#(
  parameter int unsigned RX_TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i,
  output logic       commit_o,
  output logic       commit_score_o,
  output logic [1:0] commit_state_o,
  output logic [7:0] commit_data_o,
  output logic [7:0] rx_err_cnt_o
);

  localparam int unsigned TO_W = (RX_TIMEOUT_CYCLES > 1) ? $clog2(RX_TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RX_TIMEOUT_CYCLES - 1);

  rx_state_e       state_q, state_d;
  logic [3:0]      hdr_q, hdr_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      err_q, err_d;
  logic            err_inc;
  logic            commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_HDR;
      hdr_q   <= 4'h0;
      to_q    <= '0;
      err_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    to_d    = to_q;
    err_inc = 1'b0;
    commit  = 1'b0;
    if (state_q == RX_HDR) begin
      to_d = '0;
      if (rx_done_i) begin
        if (hdr_valid(rx_data_i)) begin
          hdr_d   = rx_data_i[3:0];
          state_d = RX_DATA;
        end else begin
          err_inc = 1'b1;
        end
      end
    end else begin
      // A byte arriving on the expiry cycle still completes the frame.
      if (rx_done_i) begin
        commit  = 1'b1;
        state_d = RX_HDR;
      end else if (to_q == TO_LAST) begin
        err_inc = 1'b1;
        state_d = RX_HDR;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end
    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  assign commit_o       = commit;
  assign commit_score_o = (hdr_q[3:2] == FT_SCORE);
  assign commit_state_o = hdr_q[1:0];
  assign commit_data_o  = rx_data_i;
  assign rx_err_cnt_o   = err_q;

endmodule

// File: rtl/game_link.sv
// Link engine: frames local state/score out over the UART, parses rival frames, heartbeat and link watchdog.
// HDR tx_wr 2 cycles after a state edge; each tx_wr waits for the previous tx_done; rival fields 1 cycle after DATA.
module game_link
  import game_link_pkg::*;
#(
  parameter int unsigned HEARTBEAT_CYCLES  = 1_000_000,
  parameter int unsigned RX_TIMEOUT_CYCLES = 100_000,
  parameter int unsigned LINK_LOSS_BEATS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] state_out,
  input  logic [7:0] my_score,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_done,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  output logic [7:0] rival_score,
  output logic [1:0] rival_state,
  output logic       start_sig,
  output logic       link_up,
  output logic [7:0] rx_err_cnt
);

  localparam int unsigned HB_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);
  // The launch cycle itself is the first cycle of the next period, so launches land exactly HEARTBEAT_CYCLES apart.
  localparam logic [HB_W-1:0] HB_LOAD = (HEARTBEAT_CYCLES > 1) ? HB_W'(1) : HB_W'(0);
  localparam int unsigned LL_LIMIT = LINK_LOSS_BEATS * HEARTBEAT_CYCLES;
  localparam int unsigned LL_W = $clog2(LL_LIMIT + 1);
  localparam logic [LL_W-1:0] LL_MAX  = LL_W'(LL_LIMIT);
  localparam logic [LL_W-1:0] LL_LAST = LL_W'(LL_LIMIT - 1);

  logic       commit;
  logic       commit_score;
  logic [1:0] commit_state;
  logic [7:0] commit_data;

  game_link_rx #(
    .RX_TIMEOUT_CYCLES(RX_TIMEOUT_CYCLES)
  ) u_rx (
    .clk            (clk),
    .rst            (rst),
    .rx_data_i      (rx_data),
    .rx_done_i      (rx_done),
    .commit_o       (commit),
    .commit_score_o (commit_score),
    .commit_state_o (commit_state),
    .commit_data_o  (commit_data),
    .rx_err_cnt_o   (rx_err_cnt)
  );

  tx_state_e       tx_q, tx_d;
  logic            tx_wr_q, tx_wr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      data_byte_q, data_byte_d;
  logic            launch_state, launch_score;

  logic [1:0]      prev_q;
  logic            score_arm_q, score_arm_d;
  logic            state_pend_q, state_pend_d;
  logic            score_pend_q, score_pend_d;
  logic [HB_W-1:0] hb_q, hb_d;
  logic            hb_expire;

  logic [LL_W-1:0] ll_q, ll_d;
  logic            link_loss;
  logic            link_up_q, link_up_d;
  logic [1:0]      rival_state_q, rival_state_d;
  logic [7:0]      rival_score_q, rival_score_d;
  logic            start_q, start_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q          <= TX_IDLE;
      tx_wr_q       <= 1'b0;
      tx_data_q     <= 8'h00;
      data_byte_q   <= 8'h00;
      prev_q        <= ST_IDLE;
      score_arm_q   <= 1'b0;
      state_pend_q  <= 1'b0;
      score_pend_q  <= 1'b0;
      hb_q          <= '0;
      ll_q          <= '0;
      link_up_q     <= 1'b0;
      rival_state_q <= ST_IDLE;
      rival_score_q <= 8'h00;
      start_q       <= 1'b0;
    end else begin
      tx_q          <= tx_d;
      tx_wr_q       <= tx_wr_d;
      tx_data_q     <= tx_data_d;
      data_byte_q   <= data_byte_d;
      prev_q        <= state_out;
      score_arm_q   <= score_arm_d;
      state_pend_q  <= state_pend_d;
      score_pend_q  <= score_pend_d;
      hb_q          <= hb_d;
      ll_q          <= ll_d;
      link_up_q     <= link_up_d;
      rival_state_q <= rival_state_d;
      rival_score_q <= rival_score_d;
      start_q       <= start_d;
    end
  end

  // TX FSM: the frame contents are snapshotted at the TX_IDLE decision, never later.
  always_comb begin
    tx_d         = tx_q;
    tx_wr_d      = 1'b0;
    tx_data_d    = tx_data_q;
    data_byte_d  = data_byte_q;
    launch_state = 1'b0;
    launch_score = 1'b0;
    case (tx_q)
      TX_IDLE: begin
        if (score_pend_q) begin
          launch_score = 1'b1;
          tx_data_d    = make_hdr(FT_SCORE, state_out);
          data_byte_d  = my_score;
          tx_wr_d      = 1'b1;
          tx_d         = TX_HDR;
        end else if (state_pend_q) begin
          launch_state = 1'b1;
          tx_data_d    = make_hdr(FT_STATE, state_out);
          data_byte_d  = 8'h00;
          tx_wr_d      = 1'b1;
          tx_d         = TX_HDR;
        end
      end
      TX_HDR: tx_d = TX_WAIT_HDR;
      TX_WAIT_HDR: begin
        if (tx_done) begin
          tx_data_d = data_byte_q;
          tx_wr_d   = 1'b1;
          tx_d      = TX_DATA;
        end
      end
      TX_DATA: tx_d = TX_WAIT_DATA;
      TX_WAIT_DATA: begin
        if (tx_done) begin
          tx_d = TX_IDLE;
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  always_comb begin
    hb_expire    = (hb_q == HB_LAST);
    score_arm_d  = (state_out == ST_SCORE) && (prev_q != ST_SCORE);
    // Launch clears win over same-cycle requests: the snapshot already holds the newest state.
    state_pend_d = launch_state ? 1'b0
                 : (state_pend_q | (state_out != prev_q) | hb_expire);
    score_pend_d = launch_score ? 1'b0
                 : (score_pend_q | (score_arm_q && (state_out == ST_SCORE)));
    if (launch_state) begin
      hb_d = HB_LOAD;
    end else if (hb_expire) begin
      hb_d = hb_q;
    end else begin
      hb_d = hb_q + HB_W'(1);
    end

    link_loss     = !commit && (ll_q == LL_LAST);
    ll_d          = commit ? '0 : ((ll_q == LL_MAX) ? ll_q : ll_q + LL_W'(1));
    link_up_d     = link_up_q;
    rival_state_d = rival_state_q;
    rival_score_d = rival_score_q;
    if (commit) begin
      link_up_d     = 1'b1;
      rival_state_d = commit_state;
      if (commit_score) begin
        rival_score_d = commit_data;
      end
    end else if (link_loss) begin
      link_up_d     = 1'b0;
      rival_state_d = ST_IDLE;
    end

    start_d = (state_out == ST_WAIT) &&
              ((rival_state_q == ST_WAIT) || (rival_state_q == ST_GAME));
  end

  assign tx_wr       = tx_wr_q;
  assign tx_data     = tx_data_q;
  assign rival_score = rival_score_q;
  assign rival_state = rival_state_q;
  assign start_sig   = start_q;
  assign link_up     = link_up_q;

endmodule

// File: tb/tb_game_link.sv
// Directed bench for game_link with a small UART transmitter model that acknowledges each byte after TX_LAT cycles.
module tb_game_link;

  localparam int HB     = 100;
  localparam int TO     = 50;
  localparam int LOSS   = 4;
  localparam int TX_LAT = 4;

  logic       clk;
  logic       rst;
  logic [1:0] state_out;
  logic [7:0] my_score;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done = 1'b0;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic [7:0] rival_score;
  logic [1:0] rival_state;
  logic       start_sig;
  logic       link_up;
  logic [7:0] rx_err_cnt;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] tx_bytes[$];
  int         hdr_stamps[$];
  int         cyc       = 0;
  int         busy      = 0;
  int         byte_idx  = 0;
  int         last_done = 0;
  logic [7:0] tx_cur    = 8'h00;

  game_link #(
    .HEARTBEAT_CYCLES  (HB),
    .RX_TIMEOUT_CYCLES (TO),
    .LINK_LOSS_BEATS   (LOSS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .state_out   (state_out),
    .my_score    (my_score),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .tx_done     (tx_done),
    .tx_wr       (tx_wr),
    .tx_data     (tx_data),
    .rival_score (rival_score),
    .rival_state (rival_state),
    .start_sig   (start_sig),
    .link_up     (link_up),
    .rx_err_cnt  (rx_err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // UART transmitter model: one byte in flight, tx_done after TX_LAT cycles.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      tx_done = 1'b0;
      if (rst) begin
        busy     = 0;
        byte_idx = 0;
      end else begin
        if (busy > 0) begin
          busy--;
          if (busy == 0) begin
            tx_done   = 1'b1;
            last_done = cyc;
            chk("tx_hold", tx_data, tx_cur);
          end
        end
        if (tx_wr) begin
          chk("tx_overlap", busy, 0);
          if (byte_idx % 2 == 1) chk("data_gap", cyc - last_done, 1);
          else hdr_stamps.push_back(cyc);
          tx_bytes.push_back(tx_data);
          tx_cur = tx_data;
          busy   = TX_LAT;
          byte_idx++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int hb_base;
    int sz;
    logic saw;
    logic [7:0] exp_seq [8];
    exp_seq = '{8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA7, 8'hAA, 8'hA3, 8'h00};

    rst       = 1'b1;
    state_out = 2'b00;
    my_score  = 8'h00;
    rx_data   = 8'h00;
    rx_done   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_wr", tx_wr, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rival_score", rival_score, 8'h00);
    chk("rst_rival_state", rival_state, 2'b00);
    chk("rst_start", start_sig, 0);
    chk("rst_link_up", link_up, 0);
    chk("rst_err", rx_err_cnt, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // SCORE frame from an idle rival carrying 42
    send_byte(8'hA4);
    chk("score_before_data", rival_score, 8'h00);
    send_byte(8'h2A);
    chk("rx_score", rival_score, 8'h2A);
    chk("rx_state", rival_state, 2'b00);
    chk("rx_link_up", link_up, 1);

    // Start handshake
    state_out = 2'b01;
    send_byte(8'hA1);
    send_byte(8'h00);
    chk("rival_wait", rival_state, 2'b01);
    chk("start_reg_delay", start_sig, 0);
    @(negedge clk);
    chk("start_high", start_sig, 1);
    state_out = 2'b10;
    @(negedge clk);
    chk("start_low_game", start_sig, 0);

    // Bad sync, then a header that times out
    send_byte(8'h5F);
    chk("err_bad_sync", rx_err_cnt, 8'd1);
    send_byte(8'hA0);
    repeat (TO - 1) @(negedge clk);
    chk("err_before_timeout", rx_err_cnt, 8'd1);
    @(negedge clk);
    chk("err_timeout", rx_err_cnt, 8'd2);
    chk("timeout_state_kept", rival_state, 2'b01);

    // Local WAIT -> GAME -> SCORE frames
    state_out = 2'b00;
    repeat (40) @(negedge clk);
    base      = tx_bytes.size();
    my_score  = 8'hAA;
    state_out = 2'b01;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_wr && n < 20);
    chk("hdr_latency", n, 2);
    state_out = 2'b10;
    n = 0;
    while (tx_bytes.size() < base + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("frame2_wait_expired", (n >= 200), 0);
    state_out = 2'b11;
    n = 0;
    while (tx_bytes.size() < base + 8 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("frames_wait_expired", (n >= 300), 0);
    for (int i = 0; i < 8; i++) begin
      if (base + i < tx_bytes.size()) chk($sformatf("tx_byte%0d", i), tx_bytes[base + i], exp_seq[i]);
      else chk($sformatf("tx_byte%0d_missing", i), 0, 1);
    end

    // Heartbeat period with no rx traffic
    hb_base = hdr_stamps.size();
    n = 0;
    while (hdr_stamps.size() < hb_base + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("hb_wait_expired", (n >= 500), 0);
    for (int i = 0; i < 3; i++) begin
      if (hb_base + i < hdr_stamps.size())
        chk($sformatf("hb_gap%0d", i), hdr_stamps[hb_base + i] - hdr_stamps[hb_base + i - 1], HB);
      else chk($sformatf("hb_gap%0d_missing", i), 0, 1);
    end
    chk("hb_hdr_byte", tx_bytes[tx_bytes.size() - 1] == 8'h00 ? tx_bytes[tx_bytes.size() - 2] : tx_bytes[tx_bytes.size() - 1], 8'hA3);

    // Link loss after the last valid frame
    send_byte(8'hA2);
    send_byte(8'h00);
    chk("ll_rival_game", rival_state, 2'b10);
    chk("ll_link_up", link_up, 1);
    n = 0;
    while (link_up && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("link_fall_cycles", n, LOSS * HB);
    chk("loss_rival_idle", rival_state, 2'b00);

    // Error counter saturation
    for (int i = 0; i < 252; i++) send_byte(8'h00);
    chk("err_fe", rx_err_cnt, 8'hFE);
    for (int i = 0; i < 8; i++) send_byte(8'h00);
    chk("err_saturate", rx_err_cnt, 8'hFF);

    // Reset between HDR tx_done and the DATA byte
    state_out = 2'b01;
    n = 0;
    while (!(tx_wr && tx_data == 8'hA1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("mid_hdr_wait_expired", (n >= 300), 0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!tx_done && n < 20);
    chk("mid_done_wait_expired", (n >= 20), 0);
    rst       = 1'b1;
    state_out = 2'b00;
    #1;
    chk("async_rst_tx_data", tx_data, 8'h00);
    repeat (2) @(negedge clk);
    chk("mid_rst_tx_wr", tx_wr, 0);
    chk("mid_rst_err", rx_err_cnt, 8'h00);
    chk("mid_rst_score", rival_score, 8'h00);
    chk("mid_rst_link", link_up, 0);
    rst = 1'b0;
    sz  = tx_bytes.size();
    saw = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx_wr) saw = 1'b1;
    end
    chk("no_data_after_rst", saw, 0);
    chk("no_bytes_after_rst", tx_bytes.size(), sz);
    chk("tx_data_after_rst", tx_data, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
